// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port word RAM behind a multi-cycle load/store handshake.
//
// A request is accepted in StIdle when exactly one of mem_ld/mem_wr is high.
// busy is high for LATENCY cycles: the acceptance cycle plus LATENCY-1 cycles
// in StWait. The RAM is read or written on the edge entering StDone, and the
// FSM returns to StIdle one cycle later. While busy is high the requester is
// expected to hold its request; mem_ld/mem_wr are ignored in StWait and StDone.
//
// Ports:
//   clk          - clock; all state changes on its rising edge
//   reset        - synchronous active-high reset (RAM contents are kept)
//   address      - byte address; word index is address[log2(DEPTH_WORDS)+1:2]
//   mem_ld       - load request
//   mem_wr       - store request
//   mt           - access type: 1=B, 2=H, 3=W, 4=BU, 5=HU; others reserved
//   data_input   - store data, right-aligned
//   data_output  - last load result, sign/zero-extended; held between loads
//   busy         - high while an access is in progress (combinational)
//   fault        - one-cycle pulse, registered, in the cycle after a rejected request
//
// Parameters:
//   DEPTH_WORDS  - RAM depth in 32-bit words (power of two; index wraps)
//   LATENCY      - busy cycles per access, 1..15
//
// Build option:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned H/HU/W accesses and reserved
//   mt codes are rejected with a fault pulse. When undefined, the offending low
//   address bits are forced to zero and reserved mt codes behave as W.
module mem_access_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        mem_ld,
  input  logic        mem_wr,
  input  logic [2:0]  mt,
  input  logic [31:0] data_input,
  output logic [31:0] data_output,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  // Architectural state
  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [31:0]       dout_q;
  logic              fault_q;

  // Access captured at acceptance
  logic              store_q;
  size_e             size_q;
  logic              signed_q;
  logic [1:0]        off_q;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  // Request decode
  logic              req_one;
  logic              req_both;
  logic              reject;
  logic              accept;
  logic              finish;
  size_e             in_size;
  logic              in_signed;
  logic [1:0]        in_off;

  // Operands of the access completing this cycle
  logic              cur_store;
  size_e             cur_size;
  logic              cur_signed;
  logic [1:0]        cur_off;
  logic [IdxW-1:0]   cur_idx;
  logic [31:0]       cur_wdata;

  logic [3:0]        wr_be;
  logic [31:0]       wr_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_value;

  // Upper address bits beyond the RAM index are intentionally ignored.
  logic              unused_addr;
  assign unused_addr = ^address;

  assign req_one  = mem_ld ^ mem_wr;
  assign req_both = mem_ld & mem_wr;

  always_comb begin
    in_size   = SzWord;
    in_signed = 1'b0;
    case (mt)
      3'd1:    begin in_size = SzByte; in_signed = 1'b1; end
      3'd2:    begin in_size = SzHalf; in_signed = 1'b1; end
      3'd4:    in_size = SzByte;
      3'd5:    in_size = SzHalf;
      default: in_size = SzWord;  // W, and reserved codes treated as W
    endcase
    // Byte lane offset with misaligned low bits dropped.
    case (in_size)
      SzByte:  in_off = address[1:0];
      SzHalf:  in_off = {address[1], 1'b0};
      default: in_off = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mt_reserved;
  logic misalign;
  assign mt_reserved = (mt == 3'd0) || (mt > 3'd5);
  assign misalign    = mt_reserved
                    || ((in_size == SzHalf) && address[0])
                    || ((in_size == SzWord) && (address[1:0] != 2'b00));
  assign reject      = req_both | (req_one & misalign);
`else
  assign reject      = req_both;
`endif

  assign accept = (state_q == StIdle) && req_one && !reject;

  // With LATENCY=1 the access completes on its acceptance edge, so operands
  // come straight from the inputs rather than the capture registers.
  always_comb begin
    if (state_q == StIdle) begin
      cur_store  = mem_wr;
      cur_size   = in_size;
      cur_signed = in_signed;
      cur_off    = in_off;
      cur_idx    = address[IdxW+1:2];
      cur_wdata  = data_input;
    end else begin
      cur_store  = store_q;
      cur_size   = size_q;
      cur_signed = signed_q;
      cur_off    = off_q;
      cur_idx    = idx_q;
      cur_wdata  = wdata_q;
    end
  end

  // Edge entering StDone; reset suppresses it so an aborted store never commits.
  assign finish = !reset
               && ((accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd1)));

  always_comb begin
    case (cur_size)
      SzByte:  wr_be = 4'b0001 << cur_off;
      SzHalf:  wr_be = 4'b0011 << cur_off;
      default: wr_be = 4'b1111;
    endcase
    wr_word  = cur_wdata << {cur_off, 3'b000};
    rd_shift = mem[cur_idx] >> {cur_off, 3'b000};
    case (cur_size)
      SzByte:  ld_value = {{24{cur_signed & rd_shift[7]}}, rd_shift[7:0]};
      SzHalf:  ld_value = {{16{cur_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_value = rd_shift;
    endcase
  end

  // RAM: byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    if (finish && cur_store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[cur_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      dout_q   <= 32'h0;
      fault_q  <= 1'b0;
      store_q  <= 1'b0;
      size_q   <= SzWord;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
    end else begin
      fault_q <= (state_q == StIdle) && reject;
      if (finish && !cur_store) begin
        dout_q <= ld_value;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            store_q  <= mem_wr;
            size_q   <= in_size;
            signed_q <= in_signed;
            off_q    <= in_off;
            idx_q    <= address[IdxW+1:2];
            wdata_q  <= data_input;
            if (LATENCY == 1) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = !reset && (accept || (state_q == StWait));
  assign fault       = fault_q;
  assign data_output = dout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, per-cycle comparison
// of busy/fault/data_output, directed scenarios with literal expectations,
// then randomized traffic.
module tb_mem_access_unit;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Lat   = 3;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        mem_ld;
  logic        mem_wr;
  logic [2:0]  mt;
  logic [31:0] data_input;
  logic [31:0] data_output;
  logic        busy;
  logic        fault;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .mem_ld     (mem_ld),
    .mem_wr     (mem_wr),
    .mt         (mt),
    .data_input (data_input),
    .data_output(data_output),
    .busy       (busy),
    .fault      (fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte-addressed memory plus a transaction in flight.
  logic [7:0]  m_mem [Depth*4];
  logic [31:0] m_dout;
  logic        m_fault;
  int          m_left;   // busy cycles still to come for the accepted access
  bit          m_done;   // model is in the post-completion cycle
  bit          m_valid = 1'b0;
  bit          t_st;
  int          t_n;
  bit          t_sgn;
  int unsigned t_addr;
  logic [31:0] t_data;

  logic        obs_busy;
  logic        obs_fault;
  logic [31:0] obs_dout;

  function automatic int msize(input logic [2:0] m);
    if (m == 3'd1 || m == 3'd4) return 1;
    if (m == 3'd2 || m == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit mmisalign(input logic [2:0] m, input logic [31:0] a);
    int unsigned ua;
    ua = a;
    return (m == 3'd0) || (m > 3'd5) || ((ua % msize(m)) != 0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic complete_txn();
    longint v;
    if (t_st) begin
      for (int i = 0; i < t_n; i++) m_mem[t_addr + i] = t_data[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < t_n; i++) v = v | (longint'(m_mem[t_addr + i]) << (8 * i));
      if (t_sgn && v >= (longint'(1) << (8 * t_n - 1))) v = v - (longint'(1) << (8 * t_n));
      m_dout = 32'(v);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit free, one, both, rej, exp_busy;
    @(negedge clk);
    obs_busy  = busy;
    obs_fault = fault;
    obs_dout  = data_output;
    free = (m_left == 0) && !m_done;
    one  = mem_ld ^ mem_wr;
    both = mem_ld & mem_wr;
    rej  = both || (one && Trap && mmisalign(mt, address));
    if (m_valid) begin
      exp_busy = !reset && ((m_left > 0) || (free && one && !rej));
      check("busy", 32'(busy), 32'(exp_busy));
      check("fault", 32'(fault), 32'(m_fault));
      check("data_output", data_output, m_dout);
    end
    @(posedge clk);
    if (reset) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_dout  = 32'h0;
      m_fault = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_fault = free && rej;
      if (free && one && !rej) begin
        t_st   = mem_wr;
        t_n    = msize(mt);
        t_sgn  = (mt == 3'd1) || (mt == 3'd2);
        t_addr = address % (Depth * 4);
        t_addr = t_addr - (t_addr % t_n);
        t_data = data_input;
        if (Lat == 1) begin
          complete_txn();
          m_done = 1'b1;
        end else begin
          m_left = Lat - 1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          complete_txn();
          m_done = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end
    end
    #1;
  endtask

  // Issue one request for a single cycle, then run until busy drops.
  // Returns the number of busy cycles and whether fault was seen.
  task automatic access(input bit ld, input bit wr, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nbusy, output bit sawfault);
    mem_ld = ld; mem_wr = wr; mt = m; address = a; data_input = d;
    step();
    nbusy    = int'(obs_busy);
    sawfault = obs_fault;
    mem_ld = 1'b0; mem_wr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (obs_fault) sawfault = 1'b1;
      if (obs_busy) nbusy++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int nb;
    bit fl;
    reset = 1'b1; mem_ld = 1'b0; mem_wr = 1'b0; mt = 3'd3; address = 32'h0; data_input = 32'h0;
    m_left = 0; m_done = 1'b0; m_dout = 32'h0; m_fault = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_busy", 32'(obs_busy), 32'd0);
    check("reset_fault", 32'(obs_fault), 32'd0);
    check("reset_dout", obs_dout, 32'h0);

    // Give the words used below defined contents.
    for (int w = 0; w < 16; w++) access(1'b0, 1'b1, 3'd3, 32'(w) << 2, $urandom, nb, fl);

    // Word store then load.
    access(1'b0, 1'b1, 3'd3, 32'h10, 32'hDEADBEEF, nb, fl);
    check("w_store_busy_cycles", 32'(nb), 32'd3);
    access(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, nb, fl);
    check("w_load_busy_cycles", 32'(nb), 32'd3);
    check("w_load_value", obs_dout, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads, word readback.
    access(1'b0, 1'b1, 3'd1, 32'h13, 32'h00000080, nb, fl);
    access(1'b1, 1'b0, 3'd1, 32'h13, 32'h0, nb, fl);
    check("b_load_sext", obs_dout, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, nb, fl);
    check("bu_load_zext", obs_dout, 32'h00000080);
    access(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, nb, fl);
    check("w_load_after_b", obs_dout, 32'h80ADBEEF);

    // Halfword: aligned, then misaligned.
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, nb, fl);
    check("h_load_aligned", obs_dout, 32'hFFFFBEEF);
    access(1'b1, 1'b0, 3'd2, 32'h11, 32'h0, nb, fl);
`ifdef MEM_MISALIGN_TRAP_EN
    check("h_misalign_fault", 32'(fl), 32'd1);
    check("h_misalign_busy", 32'(nb), 32'd0);
`else
    check("h_misalign_nofault", 32'(fl), 32'd0);
    check("h_misalign_busy", 32'(nb), 32'd3);
`endif
    check("h_misalign_dout", obs_dout, 32'hFFFFBEEF);

    // Load and store together.
    access(1'b1, 1'b1, 3'd3, 32'h10, 32'h0BADF00D, nb, fl);
    check("conflict_fault", 32'(fl), 32'd1);
    check("conflict_busy", 32'(nb), 32'd0);
    access(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, nb, fl);
    check("conflict_ram_kept", obs_dout, 32'h80ADBEEF);

    // Reset in the second wait cycle of a store.
    access(1'b0, 1'b1, 3'd3, 32'h20, 32'h11111111, nb, fl);
    mem_wr = 1'b1; mt = 3'd3; address = 32'h20; data_input = 32'h12345678;
    step();
    mem_wr = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("abort_busy", 32'(obs_busy), 32'd0);
    access(1'b1, 1'b0, 3'd3, 32'h20, 32'h0, nb, fl);
    check("abort_no_write", obs_dout, 32'h11111111);

    // Load held high through completion starts a second access.
    mem_ld = 1'b1; mt = 3'd3; address = 32'h10;
    step(); step(); step();
    step();
    check("held_done_busy", 32'(obs_busy), 32'd0);
    step();
    check("held_restart_busy", 32'(obs_busy), 32'd1);
    mem_ld = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!obs_busy) break;
    end
    check("held_idle_again", 32'(obs_busy), 32'd0);
    access(1'b1, 1'b0, 3'd3, 32'h1010, 32'h0, nb, fl);
    check("index_wrap", obs_dout, 32'h80ADBEEF);

    // Random traffic, checked against the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      mem_ld     = (r < 30) || (r >= 60 && r < 65);
      mem_wr     = (r >= 30 && r < 65);
      reset      = ($urandom_range(0, 199) == 0);
      mt         = 3'($urandom_range(0, 7));
      address    = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      data_input = $urandom;
      step();
    end
    reset = 1'b0; mem_ld = 1'b0; mem_wr = 1'b0;
    for (int k = 0; k < 6; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
